// File: rtl/decode_pkg.sv
// Shared types and constants for the ID decode stage: op classes, opcodes,
// immediate formats, the EX pipeline-register state and the immediate builder.
package decode_pkg;

   typedef enum logic [3:0] {
      OPC_NOP     = 4'd0,
      OPC_OP      = 4'd1,
      OPC_OP_IMM  = 4'd2,
      OPC_LOAD    = 4'd3,
      OPC_STORE   = 4'd4,
      OPC_BRANCH  = 4'd5,
      OPC_JAL     = 4'd6,
      OPC_JALR    = 4'd7,
      OPC_LUI     = 4'd8,
      OPC_AUIPC   = 4'd9,
      OPC_FENCE   = 4'd10,
      OPC_SYSTEM  = 4'd11,
      OPC_ILLEGAL = 4'd12
   } opclass_e;

   localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
   localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
   localparam logic [6:0] OPCODE_OP       = 7'b0110011;
   localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
   localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
   localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
   localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

   // funct7 values legal on OP and on the OP_IMM shifts
   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } imm_fmt_e;

   // Control part of the EX pipeline register; XLEN-wide fields live beside it
   typedef struct packed {
      logic       valid;
      opclass_e   opclass;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] func3;
      logic [6:0] func7;
      logic       illegal;
   } ex_state_t;

   localparam ex_state_t EX_STATE_RESET = '{
      valid:   1'b0,
      opclass: OPC_NOP,
      rd:      5'd0,
      rs1:     5'd0,
      rs2:     5'd0,
      func3:   3'd0,
      func7:   7'd0,
      illegal: 1'b0
   };

   // 32-bit sign-extended immediate for a given format; R-format has none
   function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
      logic [31:0] imm;
      case (fmt)
         FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm = {instr[31:12], 12'b0};
         FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'd0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two combinational read ports, one write port.
// x0 reads zero and ignores writes; indices >= NUM_REGS read zero and are not
// written. With BYPASS_WB a same-cycle write is forwarded to a matching read.
module id_regfile #(
   parameter int XLEN      = 32,
   parameter int NUM_REGS  = 32,
   parameter bit BYPASS_WB = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata
);

   localparam int IDXW = $clog2(NUM_REGS);

   logic [XLEN-1:0] regs [NUM_REGS];

   // Write at the clock edge; reset clears every register
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != 5'd0) && (int'(waddr) < NUM_REGS)) begin
         regs[waddr[IDXW-1:0]] <= wdata;
      end
   end

   // Read port 1 with optional write-back forwarding
   always_comb begin
      rs1_data = '0;
      if ((rs1_addr != 5'd0) && (int'(rs1_addr) < NUM_REGS)) begin
         rs1_data = regs[rs1_addr[IDXW-1:0]];
         if (BYPASS_WB && we && (waddr == rs1_addr)) begin
            rs1_data = wdata;
         end
      end
   end

   // Read port 2 with optional write-back forwarding
   always_comb begin
      rs2_data = '0;
      if ((rs2_addr != 5'd0) && (int'(rs2_addr) < NUM_REGS)) begin
         rs2_data = regs[rs2_addr[IDXW-1:0]];
         if (BYPASS_WB && we && (waddr == rs2_addr)) begin
            rs2_data = wdata;
         end
      end
   end

endmodule

// File: rtl/id_decode_stage.sv
// ID stage: decodes RV32I/RV32E instructions, builds immediates, reads the
// register file, detects load-use hazards and registers into the EX register.
// Optional feature macro ILLEGAL_TRAP_EN: when defined, illegal instructions
// travel down the pipe as OPC_ILLEGAL with the raw word in ex_imm; otherwise
// they are accepted and dropped (a bubble takes their place).
//
// Handshake: a transfer happens on an edge where valid && ready are both high.
// id_ready never depends on id_valid. ex_valid and all ex_* stay stable until
// ex_ready is seen high. flush kills the EX register and refuses the incoming
// instruction in the same cycle; reset overrides everything.
module id_decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NUM_REGS  = 32,
   parameter bit BYPASS_WB = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [XLEN-1:0] id_pc,
   input  logic [31:0]     id_instr,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [3:0]      ex_opclass,
   output logic [4:0]      ex_rd,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [XLEN-1:0] ex_rs1_val,
   output logic [XLEN-1:0] ex_rs2_val,
   output logic [XLEN-1:0] ex_imm,
   output logic [2:0]      ex_func3,
   output logic [6:0]      ex_func7,
   output logic            ex_illegal,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data
);

`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   // ---------------------------------------------------------------- decode
   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   assign opcode = id_instr[6:0];
   assign f3     = id_instr[14:12];
   assign f7     = id_instr[31:25];

   imm_fmt_e fmt;
   opclass_e opc;
   logic     known;
   logic     bad_fn;

   // Opcode to format/op class, plus funct legality for OP and OP_IMM shifts
   always_comb begin
      fmt    = FMT_I;
      opc    = OPC_NOP;
      known  = 1'b1;
      bad_fn = 1'b0;
      case (opcode)
         OPCODE_OP: begin
            fmt    = FMT_R;
            opc    = OPC_OP;
            bad_fn = !((f7 == FUNCT7_BASE) ||
                       ((f7 == FUNCT7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         OPCODE_OP_IMM: begin
            fmt = FMT_I;
            opc = OPC_OP_IMM;
            if (f3 == 3'b001) begin
               bad_fn = (f7 != FUNCT7_BASE);
            end else if (f3 == 3'b101) begin
               bad_fn = (f7 != FUNCT7_BASE) && (f7 != FUNCT7_ALT);
            end
         end
         OPCODE_LOAD:     begin fmt = FMT_I; opc = OPC_LOAD;   end
         OPCODE_STORE:    begin fmt = FMT_S; opc = OPC_STORE;  end
         OPCODE_BRANCH:   begin fmt = FMT_B; opc = OPC_BRANCH; end
         OPCODE_JAL:      begin fmt = FMT_J; opc = OPC_JAL;    end
         OPCODE_JALR:     begin fmt = FMT_I; opc = OPC_JALR;   end
         OPCODE_LUI:      begin fmt = FMT_U; opc = OPC_LUI;    end
         OPCODE_AUIPC:    begin fmt = FMT_U; opc = OPC_AUIPC;  end
         OPCODE_MISC_MEM: begin fmt = FMT_I; opc = OPC_FENCE;  end
         OPCODE_SYSTEM:   begin fmt = FMT_I; opc = OPC_SYSTEM; end
         default:         known = 1'b0;
      endcase
   end

   logic       use_rd, use_rs1, use_rs2;
   logic [4:0] rd_pre, rs1_pre, rs2_pre;
   logic       bad_idx;
   logic       illegal;
   logic [4:0] dec_rd, dec_rs1, dec_rs2;

   // Register fields a format does not use are zeroed; illegal words use none
   always_comb begin
      use_rd  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
      use_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
      use_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
      rd_pre  = use_rd  ? id_instr[11:7]  : 5'd0;
      rs1_pre = use_rs1 ? id_instr[19:15] : 5'd0;
      rs2_pre = use_rs2 ? id_instr[24:20] : 5'd0;
      bad_idx = (int'(rd_pre) >= NUM_REGS) || (int'(rs1_pre) >= NUM_REGS) ||
                (int'(rs2_pre) >= NUM_REGS);
      illegal = !known || bad_fn || bad_idx || (id_instr[1:0] != 2'b11) ||
                (id_instr == 32'h0000_0000) || (id_instr == 32'hFFFF_FFFF);
      dec_rd  = illegal ? 5'd0 : rd_pre;
      dec_rs1 = illegal ? 5'd0 : rs1_pre;
      dec_rs2 = illegal ? 5'd0 : rs2_pre;
   end

   logic [XLEN-1:0] rf_rs1, rf_rs2;

   id_regfile #(
      .XLEN      (XLEN),
      .NUM_REGS  (NUM_REGS),
      .BYPASS_WB (BYPASS_WB)
   ) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .rs1_addr (dec_rs1),
      .rs2_addr (dec_rs2),
      .rs1_data (rf_rs1),
      .rs2_data (rf_rs2),
      .we       (wb_we),
      .waddr    (wb_rd),
      .wdata    (wb_data)
   );

   ex_state_t       dec_state;
   logic [XLEN-1:0] dec_imm;

   // Assemble the value the EX register loads on accept
   always_comb begin
      dec_state       = EX_STATE_RESET;
      dec_state.valid = 1'b1;
      dec_imm         = XLEN'($signed(gen_imm(id_instr, fmt)));
      if (illegal) begin
         dec_state.opclass = OPC_ILLEGAL;
         dec_state.illegal = TRAP_EN;
         dec_imm           = XLEN'(id_instr);
      end else begin
         dec_state.opclass = opc;
         dec_state.rd      = dec_rd;
         dec_state.rs1     = dec_rs1;
         dec_state.rs2     = dec_rs2;
         dec_state.func3   = ((fmt == FMT_U) || (fmt == FMT_J)) ? 3'd0 : f3;
         dec_state.func7   = (fmt == FMT_R) ? f7 : 7'd0;
      end
   end

   // ------------------------------------------------------------- handshake
   ex_state_t       ex_q;
   logic [XLEN-1:0] ex_pc_q, ex_rs1_val_q, ex_rs2_val_q, ex_imm_q;

   logic advance, hazard, accept, load_ok;

   assign advance = !ex_q.valid || ex_ready;
   assign hazard  = ex_q.valid && (ex_q.opclass == OPC_LOAD) && (ex_q.rd != 5'd0) &&
                    ((dec_rs1 == ex_q.rd) || (dec_rs2 == ex_q.rd));
   assign id_ready = !reset && !flush && advance && !hazard;
   assign accept   = id_valid && id_ready;
   assign load_ok  = TRAP_EN || !illegal;

   // EX pipeline register: reset > flush > advance (load or bubble) > hold
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q         <= EX_STATE_RESET;
         ex_pc_q      <= '0;
         ex_rs1_val_q <= '0;
         ex_rs2_val_q <= '0;
         ex_imm_q     <= '0;
      end else if (flush) begin
         ex_q.valid <= 1'b0;
      end else if (advance) begin
         if (accept && load_ok) begin
            ex_q         <= dec_state;
            ex_pc_q      <= id_pc;
            ex_rs1_val_q <= rf_rs1;
            ex_rs2_val_q <= rf_rs2;
            ex_imm_q     <= dec_imm;
         end else begin
            ex_q.valid <= 1'b0;
         end
      end
   end

   assign ex_valid   = ex_q.valid;
   assign ex_pc      = ex_pc_q;
   assign ex_opclass = ex_q.opclass;
   assign ex_rd      = ex_q.rd;
   assign ex_rs1     = ex_q.rs1;
   assign ex_rs2     = ex_q.rs2;
   assign ex_rs1_val = ex_rs1_val_q;
   assign ex_rs2_val = ex_rs2_val_q;
   assign ex_imm     = ex_imm_q;
   assign ex_func3   = ex_q.func3;
   assign ex_func7   = ex_q.func7;
   assign ex_illegal = ex_q.illegal;

endmodule
